// File: rtl/sr_pkg.sv
// Shared state encoding, per-bit command type and excitation rule for the SR bank driver.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } sr_state_e;

  typedef struct packed {
    logic s;
    logic r;
  } sr_cmd_t;

  // Set only bits that must rise and reset only bits that must fall, so s and r are never both high.
  function automatic sr_cmd_t sr_excite(input logic tgt, input logic q);
    sr_cmd_t cmd;
    cmd.s = tgt & ~q;
    cmd.r = ~tgt & q;
    return cmd;
  endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// Target handshake, bank feedback and command/status bundle of the SR bank driver.
// master = the driver block, slave = the control FSM / bank side.
interface sr_bank_driver_if #(
  parameter int WIDTH = 8
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_bits;

  modport master (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, s, r, done, err, err_bits
  );

  modport slave (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, s, r, done, err, err_bits
  );
endinterface

// File: rtl/sr_excite_gen.sv
// Combinational per-bit s/r excitation from a target vector and the bank's current q.
// Zero latency; no backpressure.
module sr_excite_gen
  import sr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_cmd_t cmd;
    assign cmd    = sr_excite(tgt_i[i], q_i[i]);
    assign s_o[i] = cmd.s;
    assign r_o[i] = cmd.r;
  end

endmodule

// File: rtl/sr_bank_driver.sv
// Drives one-cycle s/r pulses into an SR bank until q_fb matches the accepted target, with bounded retries.
// Latency: done/err 3 cycles after each drive pulse; tgt_ready only in IDLE, no queueing.
module sr_bank_driver
  import sr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  sr_bank_driver_if.master bus
);

  localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DRIVE  = DRIVE;
  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_CHECK  = CHECK;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d;

  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] exc_s;
  logic [WIDTH-1:0] exc_r;
  logic             match;

  // The first pulse is computed from the incoming target; retries use the latched one.
  assign exc_tgt = (state_q == ST_IDLE) ? bus.tgt_data : tgt_q;

  sr_excite_gen #(
    .WIDTH(WIDTH)
  ) u_excite (
    .tgt_i(exc_tgt),
    .q_i  (bus.q_fb),
    .s_o  (exc_s),
    .r_o  (exc_r)
  );

  // Case equality so an X/Z on feedback counts as a mismatch rather than a pass.
  assign match = (bus.q_fb === tgt_q);

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    s_d        = '0;
    r_d        = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_bits_d = err_bits_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.tgt_valid) begin
          tgt_d      = bus.tgt_data;
          cnt_d      = '0;
          err_bits_d = '0;
          s_d        = exc_s;
          r_d        = exc_r;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (match) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == MAX_CNT) begin
          err_d      = 1'b1;
          err_bits_d = bus.q_fb ^ tgt_q;
          state_d    = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          s_d     = exc_s;
          r_d     = exc_r;
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      cnt_q      <= '0;
      s_q        <= '0;
      r_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
    end
  end

  assign bus.tgt_ready = (state_q == ST_IDLE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_bits  = err_bits_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: an SR flop bank with stuck-at faults closes the loop,
// and an attempt-level model predicts every pulse, done/err and err_bits per cycle.
module tb_sr_bank_driver;

  localparam int W  = 4;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst;

  sr_bank_driver_if #(.WIDTH(W)) bus ();

  sr_bank_driver #(
    .WIDTH    (W),
    .MAX_RETRY(MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  // SR flop bank: s sets, r resets, stuck masks override; load port for test setup only.
  logic [W-1:0] bank_q;
  logic [W-1:0] st0, st1, ld_val;
  logic         bank_ld = 1'b0;

  always @(posedge clk) begin
    if (bank_ld) bank_q <= (ld_val & ~st0) | st1;
    else         bank_q <= (((bank_q & ~bus.r) | bus.s) & ~st0) | st1;
  end
  assign bus.q_fb = bank_q;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] exp_err_bits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_bank(input logic [W-1:0] v, input logic [W-1:0] s0, input logic [W-1:0] s1);
    bank_ld = 1'b1;
    ld_val  = v;
    st0     = s0;
    st1     = s1;
    @(negedge clk);
    bank_ld = 1'b0;
  endtask

  // Offer target t; predict the whole transaction from attempt-level rules, then check every cycle.
  task automatic run_tx(input logic [W-1:0] t, input bit hold);
    logic [W-1:0] q, se, re, bits;
    logic [W-1:0] es[16];
    logic [W-1:0] er[16];
    int  len;
    bit  is_err, fin;
    for (int i = 0; i < 16; i++) begin
      es[i] = '0;
      er[i] = '0;
    end
    len = 0; is_err = 1'b0; fin = 1'b0; bits = '0;
    @(negedge clk);
    chk("idle_ready", bus.tgt_ready, 1);
    chk("idle_done", bus.done, 0);
    chk("idle_err", bus.err, 0);
    chk("idle_err_bits", bus.err_bits, exp_err_bits);
    q = bank_q;
    for (int k = 0; k <= MR; k++) begin
      if (!fin) begin
        se = t & ~q;
        re = ~t & q;
        es[3*k+1] = se;
        er[3*k+1] = re;
        q = (((q & ~re) | se) & ~st0) | st1;
        if (q == t) begin
          len = 3*k + 4;
          fin = 1'b1;
        end else if (k == MR) begin
          len    = 3*k + 4;
          is_err = 1'b1;
          bits   = q ^ t;
          fin    = 1'b1;
        end
      end
    end
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = t;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      chk("s", bus.s, es[c]);
      chk("r", bus.r, er[c]);
      chk("s_and_r", bus.s & bus.r, 0);
      chk("ready", bus.tgt_ready, (c == len));
      chk("done", bus.done, (c == len) && !is_err);
      chk("err", bus.err, (c == len) && is_err);
      chk("err_bits", bus.err_bits, ((c == len) && is_err) ? bits : '0);
      if (hold && c < len) bus.tgt_data = W'($urandom);
      else bus.tgt_valid = 1'b0;
    end
    exp_err_bits = is_err ? bits : '0;
  endtask

  // Accept t, then assert reset at cycle at_c of the transaction and confirm nothing completes.
  task automatic rst_tx(input logic [W-1:0] t, input int at_c);
    logic [W-1:0] exp_s;
    @(negedge clk);
    exp_s = t & ~bank_q;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = t;
    for (int c = 1; c <= at_c; c++) begin
      @(negedge clk);
      bus.tgt_valid = 1'b0;
    end
    if (at_c == 1) chk("rst_pre_s", bus.s, exp_s);
    rst = 1'b1;
    #1;
    chk("rst_s", bus.s, 0);
    chk("rst_r", bus.r, 0);
    chk("rst_ready", bus.tgt_ready, 1);
    chk("rst_err_bits", bus.err_bits, 0);
    exp_err_bits = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_err", bus.err, 0);
      chk("post_rst_s", bus.s | bus.r, 0);
      chk("post_rst_ready", bus.tgt_ready, 1);
    end
  endtask

  initial begin
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = '0;
    st0 = '0; st1 = '0; ld_val = '0;
    exp_err_bits = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    chk("reset_ready", bus.tgt_ready, 1);
    chk("reset_s", bus.s, 0);
    chk("reset_r", bus.r, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_err_bits", bus.err_bits, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    load_bank(4'b0000, 4'b0000, 4'b0000);
    run_tx(4'b1010, 1'b0);
    chk("t1_bank", bank_q, 4'b1010);

    load_bank(4'b1111, 4'b0000, 4'b0000);
    run_tx(4'b0101, 1'b0);
    chk("t2_bank", bank_q, 4'b0101);

    load_bank(4'b0110, 4'b0000, 4'b0000);
    run_tx(4'b0110, 1'b0);

    load_bank(4'b0000, 4'b0001, 4'b0000);
    run_tx(4'b0001, 1'b0);
    chk("t4_err_bits", exp_err_bits, 4'b0001);

    load_bank(4'b0000, 4'b0000, 4'b0000);
    rst_tx(4'b1001, 2);
    load_bank(4'b0000, 4'b0000, 4'b0000);
    rst_tx(4'b0110, 1);
    chk("rst_drive_bank", bank_q, 4'b0000);

    load_bank(4'b0000, 4'b0000, 4'b0000);
    run_tx(4'b1100, 1'b1);
    chk("t6_bank", bank_q, 4'b1100);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] m, a, b;
      m = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      a = W'($urandom) & m;
      b = W'($urandom) & m & ~a;
      if ($urandom_range(0, 1) == 1) load_bank(W'($urandom), a, b);
      run_tx(W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
